// File: rtl/adder_pkg.sv
// Shared types for the accumulator datapath: FSM state encoding and the 32-bit word type.
package adder_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

endpackage

// File: rtl/unsigned_adder_32.sv
// Combinational 32-bit unsigned ripple-carry adder built from per-bit full-adder cells.
module unsigned_adder_32
    import adder_pkg::*;
(
    input  logic  [WORD_W-1:0] a,
    input  logic  [WORD_W-1:0] b,
    input  logic               cin,
    output logic  [WORD_W-1:0] sum,
    output logic               cout
);

    logic [WORD_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = ((a[i] ^ b[i]) & carry[i]) | (a[i] & b[i]);
    end

    assign cout = carry[WORD_W];

endmodule

// File: rtl/adder_accumulator_seq.sv
// Burst accumulator: sums N_OPS handshaked operands and presents the sum plus a sticky carry.
// Build option ACC_SATURATE_EN: clamp the accumulator to all-ones on the first carry-out.
module adder_accumulator_seq
    import adder_pkg::*;
#(
    parameter int unsigned N_OPS = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int unsigned CNT_W = $clog2(N_OPS + 1);

    if (WIDTH != WORD_W) begin : g_width_check
        $error("adder_accumulator_seq: WIDTH must equal WORD_W");
    end
    if (N_OPS < 1 || N_OPS > 255) begin : g_nops_check
        $error("adder_accumulator_seq: N_OPS must be in 1..255");
    end

    acc_state_t       state_q;
    word_t            acc_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;

    word_t            add_sum;
    logic             add_cout;
    word_t            acc_next;
    logic [CNT_W-1:0] count_inc;
    logic             last_op;

    unsigned_adder_32 u_adder (
        .a    (acc_q),
        .b    (word_t'(in_data)),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ACC_SATURATE_EN
    // Once saturated, any further non-zero operand carries out again, so the clamp holds.
    assign acc_next = add_cout ? '1 : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign count_inc = count_q + CNT_W'(1);
    assign last_op   = (count_inc == CNT_W'(N_OPS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ACCUM;
                        acc_q      <= '0;
                        count_q    <= '0;
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_next;
                        carry_q <= carry_q | add_cout;
                        count_q <= count_inc;
                        if (last_op) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = WIDTH'(acc_q);
    assign out_carry = carry_q;

endmodule

// File: tb/tb_adder_accumulator_seq.sv
// Scoreboard bench for adder_accumulator_seq with a four-operand burst.
module tb_adder_accumulator_seq;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;

    logic [32:0] exp_q[$];
    logic [31:0] m_acc;
    logic        m_carry;
    int          m_count;

    adder_accumulator_seq #(
        .N_OPS (N),
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input logic [31:0] d);
        logic [32:0] s;
        s = {1'b0, m_acc} + {1'b0, d};
        m_carry = m_carry | s[32];
`ifdef ACC_SATURATE_EN
        m_acc = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        m_acc = s[31:0];
`endif
        m_count++;
        if (m_count == int'(N)) exp_q.push_back({m_carry, m_acc});
    endtask

    task automatic begin_burst();
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_after_start", 64'(in_ready), 64'd1);
        m_acc   = '0;
        m_carry = 1'b0;
        m_count = 0;
    endtask

    task automatic send(input logic [31:0] d, input int gap, input logic start_too);
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        start    = start_too;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        model_op(d);
    endtask

    task automatic get_result(input int stall, input logic start_in_done);
        logic [32:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        rise_cyc = cyc;
        check("out_valid_rise", 64'(out_valid), 64'd1);
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(out_sum), 64'(exp[31:0]));
            start = start_in_done && (i == 0);
            @(negedge clk);
            start = 1'b0;
        end
        check("out_sum", 64'(out_sum), 64'(exp[31:0]));
        check("out_carry", 64'(out_carry), 64'(exp[32]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_acc     = '0;
        m_carry   = 1'b0;
        m_count   = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        rst_n = 1'b1;

        // Operand offered while idle must be ignored
        in_valid = 1'b1;
        in_data  = 32'd100;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_sum", 64'(out_sum), 64'd0);

        // Basic burst with latency check
        begin_burst();
        send(32'd1, 0, 1'b0);
        send(32'd2, 0, 1'b0);
        send(32'd3, 0, 1'b0);
        send(32'd4, 0, 1'b0);
        get_result(0, 1'b0);
        check("latency", 64'(rise_cyc - start_cyc), 64'd5);

        // Wrap / saturate
        @(negedge clk);
        begin_burst();
        send(32'hFFFF_FFFF, 0, 1'b0);
        send(32'd2, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        get_result(0, 1'b0);

        // Gaps and output backpressure
        begin_burst();
        send(32'd1, 1, 1'b0);
        send(32'd2, 1, 1'b0);
        send(32'd3, 2, 1'b0);
        send(32'd4, 1, 1'b0);
        get_result(5, 1'b0);

        // Start pulses in ACCUM and DONE are dropped
        begin_burst();
        send(32'd10, 0, 1'b0);
        send(32'd20, 0, 1'b1);
        send(32'd30, 0, 1'b0);
        send(32'd40, 0, 1'b0);
        get_result(2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("no_queued_start_ready", 64'(in_ready), 64'd0);
        check("no_queued_start_valid", 64'(out_valid), 64'd0);

        // Reset mid-burst discards partial work
        begin_burst();
        send(32'd9, 0, 1'b0);
        send(32'd9, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        begin_burst();
        for (int i = 0; i < 4; i++) send(32'd5, 0, 1'b0);
        get_result(0, 1'b0);

        // Back-to-back: start the cycle right after acceptance
        begin_burst();
        send(32'hFFFF_FFF0, 0, 1'b0);
        send(32'h20, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        get_result(0, 1'b0);
        begin_burst();
        send(32'd7, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        send(32'd0, 0, 1'b0);
        send(32'd1, 0, 1'b0);
        get_result(0, 1'b0);

        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_accumulator_seq.md
# adder_accumulator_seq

Sequential accumulation stage directly downstream of the team's 32-bit unsigned full-adder datapath. It accepts a burst of N_OPS unsigned 32-bit operands over a valid/ready handshake and accumulates them with one add per accepted operand. It then presents the final sum plus a sticky carry-out flag on an output valid/ready handshake. The add itself is done by a combinational 32-bit unsigned adder instance (sum = a^b^cin, cout = (a^b)&cin | a&b per bit, rippled), with cin tied to 0.

## Interface
- N_OPS, 8, operands per burst; legal range 1..255
- WIDTH, 32, operand/accumulator width; the block is verified at 32 only
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse that begins a burst; honoured only in IDLE
- in_valid  input  1  operand valid
- in_ready  output  1  operand ready; high only in ACCUM
- in_data  input  WIDTH  unsigned operand
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  result accepted by the consumer
- out_sum  output  WIDTH  accumulated sum
- out_carry  output  1  sticky: high if any add in the burst produced cout=1

## Operation
- FSM has three states: IDLE, ACCUM, DONE.
- IDLE, with start=1: go to ACCUM; clear acc, count and carry.
- ACCUM: in_ready=1. Each cycle with in_valid&in_ready:
  - acc <= adder.sum(acc, in_data)
  - carry <= carry | adder.cout
  - count <= count+1
- ACCUM to DONE: on the handshake that makes count == N_OPS.
- DONE: out_valid=1. out_sum and out_carry hold stable until out_valid&out_ready, then go to IDLE.
- start outside IDLE is ignored and is not queued.
- in_valid outside ACCUM is ignored; in_ready=0 there.
- Arithmetic is unsigned and modulo 2^WIDTH (wrap-around) unless saturation is compiled in.
- count width is $clog2(N_OPS+1).
- A zero operand is a legal handshake: it counts toward N_OPS and leaves acc unchanged.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, acc=0, count=0, carry=0. Outputs after reset: in_ready=0, out_valid=0, out_sum=0, out_carry=0.
- Reset has priority over every other input in every state, including mid-burst and during DONE; partial results are discarded.
- start sampled at edge k: in_ready=1 from cycle k+1.
- Throughput: one operand per cycle.
- Latency: out_valid rises the cycle after the final operand handshake.
- Minimum burst time from start to out_valid: N_OPS+1 cycles.
- A result accepted at edge m: IDLE at m+1. A start sampled at m+1 is honoured, so start to start is N_OPS+2 cycles at minimum.
- in_ready, out_valid, out_sum and out_carry are registered-state decodes and do not depend combinationally on any input.

## Configuration
- ACC_SATURATE_EN
  - Defined: when an add produces cout=1, acc loads all-ones (32'hFFFF_FFFF) and stays all-ones for the rest of the burst. out_carry is still set.
  - Undefined: acc wraps modulo 2^WIDTH. out_carry is set identically.

## Structure
- Shared package adder_pkg:
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t
  - localparam WORD_W = 32
  - typedef logic [WORD_W-1:0] word_t
- Sub-module unsigned_adder_32: combinational, ports a, b, cin, sum, cout. Instantiated once with cin=0.
- FSM, counter and registers live in adder_accumulator_seq.

## Test plan
- Basic burst: N_OPS=4, operands 1,2,3,4 back-to-back after start -> out_valid 5 cycles after start, out_sum=10, out_carry=0.
- Wrap: operands 32'hFFFF_FFFF, 2, 0, 0 -> without macro: out_sum=1, out_carry=1. With ACC_SATURATE_EN: out_sum=32'hFFFF_FFFF, out_carry=1.
- Gaps and backpressure: in_valid toggled 1/0, then out_ready held 0 for 5 cycles -> same sum as the gapless run; out_sum stable and out_valid high throughout the stall.
- Ignored start: start pulsed during ACCUM and during DONE -> no effect on count or sum; only one result is produced.
- Reset mid-burst: rst_n=0 after 2 of 4 operands -> next cycle in_ready=0, out_valid=0, out_sum=0. A fresh burst of 5,5,5,5 yields 20.
- Back-to-back bursts: start asserted the cycle after result acceptance -> honoured; second burst 7,0,0,1 gives out_sum=8 with carry cleared.
